// File: rtl/fp_round_pkg.sv
// Shared types and constants for the RNE rounding scheduler.
// Latency: n/a (types only). Backpressure: n/a.
package fp_round_pkg;

    localparam int MW   = 27;
    localparam int EW   = 8;
    localparam int FW   = 23;
    localparam int TAGW = 4;

    localparam logic [2:0]    GRS_HALF = 3'b100;
    localparam logic [EW-1:0] EXP_MAX  = '1;

    typedef struct packed {
        logic            src;
        logic [TAGW-1:0] tag;
        logic            sign;
        logic [EW-1:0]   exp;
        logic [MW-1:0]   man;
    } round_req_t;

endpackage

// File: rtl/round_rne.sv
// Combinational round-to-nearest-even of a normalized mantissa with GRS bits.
// Latency: 0 cycles. Backpressure: none, pure combinational.
module round_rne
    import fp_round_pkg::*;
(
    input  logic [MW-1:0] i_man,
    input  logic [EW-1:0] i_exp,
    output logic [FW-1:0] o_man,
    output logic [EW-1:0] o_exp,
    output logic          o_ovf
);

    logic          w_inc;
    logic [MW-3:0] w_t;
    logic [EW-1:0] w_exp_inc;

    always_comb begin
        w_inc     = (i_man[2:0] > GRS_HALF) ||
                    ((i_man[2:0] == GRS_HALF) && i_man[3]);
        w_t       = {1'b0, i_man[MW-1:3]} + {{(MW-3){1'b0}}, w_inc};
        w_exp_inc = i_exp + {{(EW-1){1'b0}}, 1'b1};

        o_man = w_t[FW-1:0];
        o_exp = i_exp;
        o_ovf = 1'b0;

        // Inf/NaN pass their payload through untouched.
        if (i_exp == EXP_MAX) begin
            o_man = i_man[MW-2:3];
        end else if (w_t[MW-3]) begin
            o_exp = w_exp_inc;
            if (w_exp_inc == EXP_MAX) begin
                o_man = '0;
                o_ovf = 1'b1;
            end else begin
                o_man = w_t[FW:1];
            end
        end
    end

endmodule

// File: rtl/fp_round_scheduler.sv
// Round-robin share of one RNE rounding stage between two FMA result producers.
// Latency: 2 cycles accept-to-result. Backpressure: res_ready low holds S2, then S1, then drops req*_ready.
module fp_round_scheduler #(
    parameter int MW   = fp_round_pkg::MW,
    parameter int EW   = fp_round_pkg::EW,
    parameter int TAGW = fp_round_pkg::TAGW
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_sign,
    input  logic [EW-1:0]   req0_exp,
    input  logic [MW-1:0]   req0_man,
    input  logic [TAGW-1:0] req0_tag,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_sign,
    input  logic [EW-1:0]   req1_exp,
    input  logic [MW-1:0]   req1_man,
    input  logic [TAGW-1:0] req1_tag,

    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_src,
    output logic [TAGW-1:0] res_tag,
    output logic            res_sign,
    output logic [EW-1:0]   res_exp,
    output logic [22:0]     res_man,
    output logic            res_ovf
);

    fp_round_pkg::round_req_t r_s1;
    fp_round_pkg::round_req_t w_sel;
    logic                     r_s1_valid;
    logic                     r_rr_ptr;

    logic                     r_res_valid;
    logic                     r_res_src;
    logic [TAGW-1:0]          r_res_tag;
    logic                     r_res_sign;
    logic [EW-1:0]            r_res_exp;
    logic [22:0]              r_res_man;
    logic                     r_res_ovf;

    logic                     w_s2_free;
    logic                     w_s1_adv;
    logic                     w_s1_free;
    logic                     w_gnt0;
    logic                     w_gnt1;
    logic                     w_accept;
    logic [22:0]              w_rnd_man;
    logic [EW-1:0]            w_rnd_exp;
    logic                     w_rnd_ovf;

    assign w_s2_free = !r_res_valid || res_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign w_s1_free = !r_s1_valid || w_s1_adv;

    // r_rr_ptr names the requester favoured when both are valid.
    assign w_gnt0 = req0_valid && (!req1_valid || !r_rr_ptr);
    assign w_gnt1 = req1_valid && (!req0_valid ||  r_rr_ptr);

    assign req0_ready = w_gnt0 && w_s1_free;
    assign req1_ready = w_gnt1 && w_s1_free;
    assign w_accept   = req0_ready || req1_ready;

    always_comb begin
        w_sel.src  = w_gnt1;
        w_sel.tag  = req0_tag;
        w_sel.sign = req0_sign;
        w_sel.exp  = req0_exp;
        w_sel.man  = req0_man;
        if (w_gnt1) begin
            w_sel.tag  = req1_tag;
            w_sel.sign = req1_sign;
            w_sel.exp  = req1_exp;
            w_sel.man  = req1_man;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
            r_rr_ptr   <= 1'b0;
        end else if (w_accept) begin
            r_s1       <= w_sel;
            r_s1_valid <= 1'b1;
            r_rr_ptr   <= ~w_sel.src;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    round_rne u_round (
        .i_man (r_s1.man),
        .i_exp (r_s1.exp),
        .o_man (w_rnd_man),
        .o_exp (w_rnd_exp),
        .o_ovf (w_rnd_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_src   <= 1'b0;
            r_res_tag   <= '0;
            r_res_sign  <= 1'b0;
            r_res_exp   <= '0;
            r_res_man   <= '0;
            r_res_ovf   <= 1'b0;
        end else if (w_s1_adv) begin
            r_res_valid <= 1'b1;
            r_res_src   <= r_s1.src;
            r_res_tag   <= r_s1.tag;
            r_res_sign  <= r_s1.sign;
            r_res_exp   <= w_rnd_exp;
            r_res_man   <= w_rnd_man;
            r_res_ovf   <= w_rnd_ovf;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_src   = r_res_src;
    assign res_tag   = r_res_tag;
    assign res_sign  = r_res_sign;
    assign res_exp   = r_res_exp;
    assign res_man   = r_res_man;
    assign res_ovf   = r_res_ovf;

endmodule

// File: tb/tb_fp_round_scheduler.sv
// Directed bench for fp_round_scheduler: rounding vectors, arbitration, stall, reset.
// Latency: n/a. Backpressure: driven explicitly through res_ready.
module tb_fp_round_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_sign;
    logic [7:0]  req0_exp;
    logic [26:0] req0_man;
    logic [3:0]  req0_tag;
    logic        req1_valid, req1_ready, req1_sign;
    logic [7:0]  req1_exp;
    logic [26:0] req1_man;
    logic [3:0]  req1_tag;
    logic        res_valid, res_ready, res_src, res_sign, res_ovf;
    logic [3:0]  res_tag;
    logic [7:0]  res_exp;
    logic [22:0] res_man;

    int checks   = 0;
    int failures = 0;

    logic       arb_src [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] arb_tag [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    logic [3:0] q0_tag  [2] = '{4'h1, 4'h3};
    logic [3:0] q1_tag  [2] = '{4'h2, 4'h4};

    always #5 clk = ~clk;

    fp_round_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_sign  (req0_sign),
        .req0_exp   (req0_exp),
        .req0_man   (req0_man),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_sign  (req1_sign),
        .req1_exp   (req1_exp),
        .req1_man   (req1_man),
        .req1_tag   (req1_tag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_src    (res_src),
        .res_tag    (res_tag),
        .res_sign   (res_sign),
        .res_exp    (res_exp),
        .res_man    (res_man),
        .res_ovf    (res_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // One isolated transaction on a single requester, checked at exact latency.
    task automatic round_one(input string nm, input logic src, input logic sgn,
                             input logic [7:0] e, input logic [26:0] m, input logic [3:0] tg,
                             input logic [22:0] xm, input logic [7:0] xe, input logic xo);
        res_ready = 1'b1;
        if (src) begin
            req1_valid = 1'b1; req1_sign = sgn; req1_exp = e; req1_man = m; req1_tag = tg;
        end else begin
            req0_valid = 1'b1; req0_sign = sgn; req0_exp = e; req0_man = m; req0_tag = tg;
        end
        #1;
        chk({nm, "_rdy"}, src ? req1_ready : req0_ready, 1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({nm, "_early"}, res_valid, 0);
        step();
        chk({nm, "_vld"},  res_valid, 1);
        chk({nm, "_src"},  res_src,   src);
        chk({nm, "_tag"},  res_tag,   tg);
        chk({nm, "_sign"}, res_sign,  sgn);
        chk({nm, "_man"},  res_man,   xm);
        chk({nm, "_exp"},  res_exp,   xe);
        chk({nm, "_ovf"},  res_ovf,   xo);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_sign = 1'b0; req0_exp = '0; req0_man = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_sign = 1'b0; req1_exp = '0; req1_man = '0; req1_tag = '0;
        res_ready  = 1'b0;
        #1;
        chk("rst_vld", res_valid, 0);
        chk("rst_man", res_man,   0);
        chk("rst_tag", res_tag,   0);
        chk("rst_exp", res_exp,   0);
        chk("rst_rdy", {req1_ready, req0_ready}, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // RNE vectors
        round_one("tie_odd",  1'b0, 1'b1, 8'h80, 27'h400000C, 4'hA, 23'h000002, 8'h80, 1'b0);
        round_one("tie_even", 1'b1, 1'b0, 8'h80, 27'h4000004, 4'hB, 23'h000000, 8'h80, 1'b0);
        round_one("above",    1'b0, 1'b0, 8'h80, 27'h4000005, 4'hC, 23'h000001, 8'h80, 1'b0);
        round_one("carry",    1'b1, 1'b0, 8'h80, 27'h7FFFFFD, 4'hD, 23'h000000, 8'h81, 1'b0);
        round_one("ovf",      1'b0, 1'b1, 8'hFE, 27'h7FFFFFD, 4'hE, 23'h000000, 8'hFF, 1'b1);
        round_one("infnan",   1'b1, 1'b0, 8'hFF, 27'h5555557, 4'hF, 23'h2AAAAA, 8'hFF, 1'b0);

        // Arbitration: both requesters keep offering until each has two accepts
        do_reset();
        step();
        res_ready = 1'b1;
        begin
            int n0 = 0;
            int n1 = 0;
            req0_man = 27'h4000008; req0_exp = 8'h80;
            req1_man = 27'h4000010; req1_exp = 8'h80;
            for (int c = 0; c < 6; c++) begin
                logic a0, a1;
                req0_valid = (n0 < 2);
                req1_valid = (n1 < 2);
                if (n0 < 2) req0_tag = q0_tag[n0];
                if (n1 < 2) req1_tag = q1_tag[n1];
                #1;
                if (c < 4) begin
                    chk("arb_rdy0", req0_ready, (c % 2 == 0));
                    chk("arb_rdy1", req1_ready, (c % 2 == 1));
                end
                if (c >= 2) begin
                    chk("arb_vld", res_valid, 1);
                    chk("arb_src", res_src, arb_src[c-2]);
                    chk("arb_tag", res_tag, arb_tag[c-2]);
                end else begin
                    chk("arb_lat", res_valid, 0);
                end
                a0 = req0_valid && req0_ready;
                a1 = req1_valid && req1_ready;
                step();
                if (a0) n0++;
                if (a1) n1++;
            end
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            chk("arb_drain", res_valid, 0);
        end

        // Backpressure: stall downstream while a stream is pending
        do_reset();
        step();
        res_ready = 1'b0;
        req0_man = 27'h400000C; req0_exp = 8'h80; req0_sign = 1'b0;
        req0_valid = 1'b1; req0_tag = 4'h5;
        #1;
        chk("bp_rdy_c0", req0_ready, 1);
        step();
        req0_tag = 4'h6;
        #1;
        chk("bp_rdy_c1", req0_ready, 1);
        step();
        req0_tag = 4'h7;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_rdy_hold", req0_ready, 0);
            chk("bp_vld_hold", res_valid, 1);
            chk("bp_tag_hold", res_tag, 4'h5);
            chk("bp_man_hold", res_man, 23'h000002);
            step();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_rdy_rel", req0_ready, 1);
        chk("bp_tag_t5", res_tag, 4'h5);
        step();
        req0_valid = 1'b0;
        chk("bp_tag_t6", res_tag, 4'h6);
        chk("bp_vld_t6", res_valid, 1);
        step();
        chk("bp_tag_t7", res_tag, 4'h7);
        chk("bp_vld_t7", res_valid, 1);
        step();
        chk("bp_empty", res_valid, 0);

        // Async reset with both stages full
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_tag = 4'h9;
        step();
        req0_tag = 4'hA;
        step();
        req0_valid = 1'b0;
        chk("ar_full_vld", res_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld", res_valid, 0);
        chk("ar_tag", res_tag, 0);
        chk("ar_man", res_man, 0);
        step();
        rst_n = 1'b1;
        res_ready = 1'b1;
        step();
        chk("ar_nopart1", res_valid, 0);
        step();
        chk("ar_nopart2", res_valid, 0);
        req0_valid = 1'b1; req0_tag = 4'h3;
        req1_valid = 1'b1; req1_tag = 4'hC;
        #1;
        chk("ar_gnt0", req0_ready, 1);
        chk("ar_gnt1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        chk("ar_res_src", res_src, 0);
        chk("ar_res_tag", res_tag, 4'h3);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
